// File: rtl/bandera_multi.sv
// Multi-channel read-flag generator: each channel runs an independent period
// counter and raises a registered flag for the leading cycles of every period.
module bandera_multi #(
  parameter int unsigned CH       = 4,
  parameter int unsigned CW       = 5,
  parameter int unsigned DEF_LAST = 24,
  parameter int unsigned DEF_HIGH = 10
) (
  input  logic             clkBM,
  input  logic             resetBM,
  input  logic [CH-1:0]    enBM,
  input  logic [CH-1:0]    oneshotBM,
  input  logic [CH*CW-1:0] lastBM,
  input  logic [CH*CW-1:0] highBM,
  output logic [CH-1:0]    BandBM,
  output logic [CH-1:0]    wrapBM,
  output logic [CH-1:0]    doneBM,
  output logic [CH-1:0]    activeBM
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } chState_t;

  for (genvar i = 0; i < int'(CH); i++) begin : gCh
    chState_t        state, stateNxt;
    logic [CW-1:0]   cnt, cntNxt;
    logic [CW-1:0]   lastL, lastNxt;
    logic [CW-1:0]   highL, highNxt;
    logic            osL, osNxt;
    logic            band, bandNxt;
    logic            wrap, wrapNxt;
    logic            done, doneNxt;
    logic            active, activeNxt;
    logic [CW-1:0]   cntInc;

    // cnt < lastL whenever cntInc is used, so it cannot overflow
    assign cntInc = cnt + CW'(1);

    always_ff @(posedge clkBM or posedge resetBM) begin
      if (resetBM) begin
        state  <= IDLE;
        cnt    <= '0;
        lastL  <= CW'(DEF_LAST);
        highL  <= CW'(DEF_HIGH);
        osL    <= 1'b0;
        band   <= 1'b0;
        wrap   <= 1'b0;
        done   <= 1'b0;
        active <= 1'b0;
      end else begin
        state  <= stateNxt;
        cnt    <= cntNxt;
        lastL  <= lastNxt;
        highL  <= highNxt;
        osL    <= osNxt;
        band   <= bandNxt;
        wrap   <= wrapNxt;
        done   <= doneNxt;
        active <= activeNxt;
      end
    end

    always_comb begin
      stateNxt  = state;
      cntNxt    = cnt;
      lastNxt   = lastL;
      highNxt   = highL;
      osNxt     = osL;
      bandNxt   = band;
      wrapNxt   = 1'b0;
      doneNxt   = done;
      activeNxt = active;

      if (!enBM[i]) begin
        // enable low dominates everything, including a coincident wrap
        stateNxt  = IDLE;
        cntNxt    = '0;
        bandNxt   = 1'b0;
        doneNxt   = 1'b0;
        activeNxt = 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            stateNxt  = RUN;
            cntNxt    = '0;
            lastNxt   = lastBM[i*CW +: CW];
            highNxt   = highBM[i*CW +: CW];
            osNxt     = oneshotBM[i];
            bandNxt   = 1'b1;
            doneNxt   = 1'b0;
            activeNxt = 1'b1;
          end
          RUN: begin
            if (cnt != lastL) begin
              cntNxt  = cntInc;
              bandNxt = (cntInc <= highL);
            end else if (!osL) begin
              cntNxt  = '0;
              lastNxt = lastBM[i*CW +: CW];
              highNxt = highBM[i*CW +: CW];
              osNxt   = oneshotBM[i];
              bandNxt = 1'b1;
              wrapNxt = 1'b1;
            end else begin
              stateNxt  = DONE;
              bandNxt   = 1'b0;
              activeNxt = 1'b0;
              doneNxt   = 1'b1;
              wrapNxt   = 1'b1;
            end
          end
          DONE: begin
            bandNxt   = 1'b0;
            activeNxt = 1'b0;
            doneNxt   = 1'b1;
          end
          default: begin
            stateNxt  = IDLE;
            cntNxt    = '0;
            bandNxt   = 1'b0;
            doneNxt   = 1'b0;
            activeNxt = 1'b0;
          end
        endcase
      end
    end

    assign BandBM[i]   = band;
    assign wrapBM[i]   = wrap;
    assign doneBM[i]   = done;
    assign activeBM[i] = active;
  end

endmodule

// File: tb/tb_bandera_multi.sv
// Self-checking bench for bandera_multi: directed scenarios plus randomized
// traffic, compared every cycle against a period-position reference model.
module tb_bandera_multi;
  localparam int CH = 4;
  localparam int CW = 5;

  logic             clkBM = 1'b0;
  logic             resetBM;
  logic [CH-1:0]    enBM;
  logic [CH-1:0]    oneshotBM;
  logic [CH*CW-1:0] lastBM;
  logic [CH*CW-1:0] highBM;
  logic [CH-1:0]    BandBM, wrapBM, doneBM, activeBM;

  bandera_multi #(.CH(CH), .CW(CW), .DEF_LAST(24), .DEF_HIGH(10)) dut (
    .clkBM(clkBM), .resetBM(resetBM), .enBM(enBM), .oneshotBM(oneshotBM),
    .lastBM(lastBM), .highBM(highBM), .BandBM(BandBM), .wrapBM(wrapBM),
    .doneBM(doneBM), .activeBM(activeBM)
  );

  always #5 clkBM = ~clkBM;

  int checks = 0;
  int errors = 0;

  // model: 0 idle, 1 running, 2 finished one-shot; pos = cycle within period
  int mMode[CH];
  int mPos[CH];
  int mLast[CH];
  int mHigh[CH];
  bit mOs[CH];
  bit mWrap[CH];

  wire [4*CH-1:0] dutOut = {BandBM, wrapBM, doneBM, activeBM};

  task automatic modelReset();
    for (int i = 0; i < CH; i++) begin
      mMode[i] = 0; mPos[i] = 0; mLast[i] = 24; mHigh[i] = 10;
      mOs[i] = 1'b0; mWrap[i] = 1'b0;
    end
  endtask

  task automatic modelStep();
    for (int i = 0; i < CH; i++) begin
      mWrap[i] = 1'b0;
      if (!enBM[i]) begin
        mMode[i] = 0; mPos[i] = 0;
      end else if (mMode[i] == 0) begin
        mMode[i] = 1; mPos[i] = 0;
        mLast[i] = int'(lastBM[i*CW +: CW]);
        mHigh[i] = int'(highBM[i*CW +: CW]);
        mOs[i]   = oneshotBM[i];
      end else if (mMode[i] == 1) begin
        if (mPos[i] < mLast[i]) mPos[i] = mPos[i] + 1;
        else begin
          mWrap[i] = 1'b1;
          if (mOs[i]) mMode[i] = 2;
          else begin
            mPos[i]  = 0;
            mLast[i] = int'(lastBM[i*CW +: CW]);
            mHigh[i] = int'(highBM[i*CW +: CW]);
            mOs[i]   = oneshotBM[i];
          end
        end
      end
    end
  endtask

  function automatic logic [4*CH-1:0] expOut();
    logic [CH-1:0] b, w, d, a;
    for (int i = 0; i < CH; i++) begin
      b[i] = (mMode[i] == 1) && (mPos[i] <= mHigh[i]);
      w[i] = mWrap[i];
      d[i] = (mMode[i] == 2);
      a[i] = (mMode[i] == 1);
    end
    return {b, w, d, a};
  endfunction

  task automatic tick();
    @(posedge clkBM);
    if (resetBM) modelReset();
    else modelStep();
    #1;
  endtask

  task automatic setCfg(input int ch, input int last, input int high, input bit os);
    lastBM[ch*CW +: CW] = CW'(last);
    highBM[ch*CW +: CW] = CW'(high);
    oneshotBM[ch]       = os;
  endtask

  task automatic test_reset();
    resetBM = 1'b1; enBM = '0; oneshotBM = '0; lastBM = '0; highBM = '0;
    modelReset();
    #1;
    checks++;
    if (dutOut !== '0) begin
      errors++; $display("FAIL reset_out got=%h want=%h", dutOut, 16'h0);
    end
    tick(); tick();
    @(negedge clkBM); resetBM = 1'b0;
    tick();
    checks++;
    if (dutOut !== expOut()) begin
      errors++; $display("FAIL reset_idle got=%h want=%h", dutOut, expOut());
    end
  endtask

  task automatic test_continuous();
    int bandCnt = 0, wrapCnt = 0;
    setCfg(0, 24, 10, 1'b0);
    enBM[0] = 1'b1;
    for (int c = 0; c < 50; c++) begin
      tick();
      checks++;
      if (dutOut !== expOut()) begin
        errors++; $display("FAIL cont_cycle%0d got=%h want=%h", c, dutOut, expOut());
      end
      bandCnt += int'(BandBM[0]);
      wrapCnt += int'(wrapBM[0]);
      if (wrapBM[0]) begin
        checks++;
        if (BandBM[0] !== 1'b1) begin
          errors++; $display("FAIL cont_wrap_band got=%b want=1", BandBM[0]);
        end
      end
    end
    checks++;
    if (bandCnt != 22) begin
      errors++; $display("FAIL cont_band_count got=%0d want=22", bandCnt);
    end
    checks++;
    if (wrapCnt != 1) begin
      errors++; $display("FAIL cont_wrap_count got=%0d want=1", wrapCnt);
    end
    enBM[0] = 1'b0;
    tick();
  endtask

  task automatic test_oneshot();
    int bandCnt = 0, doneCnt = 0, wrapCnt = 0;
    setCfg(1, 7, 2, 1'b1);
    enBM[1] = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick();
      checks++;
      if (dutOut !== expOut()) begin
        errors++; $display("FAIL os_cycle%0d got=%h want=%h", c, dutOut, expOut());
      end
      bandCnt += int'(BandBM[1]);
      doneCnt += int'(doneBM[1]);
      wrapCnt += int'(wrapBM[1]);
      if (c == 8) begin
        checks++;
        if ({wrapBM[1], doneBM[1]} !== 2'b11) begin
          errors++; $display("FAIL os_done_rise got=%b want=11", {wrapBM[1], doneBM[1]});
        end
      end
    end
    checks++;
    if (bandCnt != 3 || doneCnt != 4 || wrapCnt != 1) begin
      errors++; $display("FAIL os_counts got=%0d/%0d/%0d want=3/4/1", bandCnt, doneCnt, wrapCnt);
    end
    enBM[1] = 1'b0;
    tick();
    checks++;
    if (doneBM[1] !== 1'b0 || dutOut !== expOut()) begin
      errors++; $display("FAIL os_clear got=%h want=%h", dutOut, expOut());
    end
    enBM[1] = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (dutOut !== expOut()) begin
        errors++; $display("FAIL os_restart%0d got=%h want=%h", c, dutOut, expOut());
      end
    end
    enBM[1] = 1'b0;
    tick();
  endtask

  task automatic test_enable_drop();
    int bandCnt = 0;
    setCfg(2, 24, 10, 1'b0);
    enBM[2] = 1'b1;
    repeat (6) tick();
    enBM[2] = 1'b0;
    tick();
    checks++;
    if ({BandBM[2], activeBM[2], wrapBM[2]} !== 3'b000 || dutOut !== expOut()) begin
      errors++; $display("FAIL drop_mid got=%h want=%h", dutOut, expOut());
    end
    enBM[2] = 1'b1;
    for (int c = 0; c < 25; c++) begin
      tick();
      checks++;
      if (dutOut !== expOut()) begin
        errors++; $display("FAIL drop_reen%0d got=%h want=%h", c, dutOut, expOut());
      end
      bandCnt += int'(BandBM[2]);
    end
    checks++;
    if (bandCnt != 11) begin
      errors++; $display("FAIL drop_band_count got=%0d want=11", bandCnt);
    end
    enBM[2] = 1'b0;
    tick();
  endtask

  task automatic test_edge_cfg();
    int wrapCnt = 0, bandCnt = 0;
    setCfg(3, 0, 0, 1'b0);
    enBM[3] = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++;
      if (dutOut !== expOut()) begin
        errors++; $display("FAIL last0_cycle%0d got=%h want=%h", c, dutOut, expOut());
      end
      wrapCnt += int'(wrapBM[3]);
    end
    checks++;
    if (wrapCnt != 5) begin
      errors++; $display("FAIL last0_wraps got=%0d want=5", wrapCnt);
    end
    enBM[3] = 1'b0;
    tick();
    setCfg(3, 31, 31, 1'b0);
    enBM[3] = 1'b1;
    wrapCnt = 0;
    for (int c = 0; c < 66; c++) begin
      tick();
      checks++;
      if (dutOut !== expOut()) begin
        errors++; $display("FAIL max_cycle%0d got=%h want=%h", c, dutOut, expOut());
      end
      wrapCnt += int'(wrapBM[3]);
      bandCnt += int'(BandBM[3]);
    end
    checks++;
    if (wrapCnt != 2 || bandCnt != 66) begin
      errors++; $display("FAIL max_counts got=%0d/%0d want=2/66", wrapCnt, bandCnt);
    end
    enBM[3] = 1'b0;
    tick();
  endtask

  task automatic test_cfg_change();
    int band1 = 0, band2 = 0, wraps = 0;
    setCfg(0, 24, 10, 1'b0);
    enBM[0] = 1'b1;
    for (int c = 0; c < 36; c++) begin
      tick();
      if (c == 3) setCfg(0, 9, 4, 1'b0);
      checks++;
      if (dutOut !== expOut()) begin
        errors++; $display("FAIL cfg_cycle%0d got=%h want=%h", c, dutOut, expOut());
      end
      if (c < 25) band1 += int'(BandBM[0]);
      else begin
        if (c < 35) band2 += int'(BandBM[0]);
        wraps += int'(wrapBM[0]);
      end
    end
    checks++;
    if (band1 != 11 || band2 != 5 || wraps != 2) begin
      errors++; $display("FAIL cfg_counts got=%0d/%0d/%0d want=11/5/2", band1, band2, wraps);
    end
    enBM[0] = 1'b0;
    tick();
  endtask

  task automatic test_reset_indep();
    for (int i = 0; i < CH; i++)
      setCfg(i, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
    enBM = '1;
    for (int c = 0; c < 300; c++) begin
      tick();
      checks++;
      if (dutOut !== expOut()) begin
        errors++; $display("FAIL rand_cycle%0d got=%h want=%h", c, dutOut, expOut());
      end
      if (c == 150) begin
        #2 resetBM = 1'b1;
        modelReset();
        #1;
        checks++;
        if (dutOut !== '0) begin
          errors++; $display("FAIL async_reset got=%h want=%h", dutOut, 16'h0);
        end
        @(negedge clkBM); resetBM = 1'b0;
      end
      for (int i = 0; i < CH; i++) begin
        if ($urandom_range(0, 19) == 0) enBM[i] = ~enBM[i];
        if ($urandom_range(0, 7) == 0)
          setCfg(i, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
      end
    end
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_oneshot();
    test_enable_drop();
    test_edge_cfg();
    test_cfg_change();
    test_reset_indep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bandera_multi.md
Name: bandera_multi

Overview:
- Parametrised, multi-channel successor to the single-channel read-flag generator.
- Each channel runs an independent period counter while its enable is held. It raises a flag for a programmable number of leading cycles of each period.
- Each channel supports continuous or one-shot mode and reports period wrap and one-shot completion.
- Sits between the control FSM and the read/write sequencers, which consume the flags as timing windows.

Parameters:
- CH, 4, number of independent channels.
- CW, 5, counter width per channel.
- DEF_LAST, 24, reset value of each channel's latched last-count (period = last+1 cycles).
- DEF_HIGH, 10, reset value of each channel's latched high-count (flag high for counts 0..high).

Ports:
- clkBM  input  1  clock; all state updates on rising edge.
- resetBM  input  1  asynchronous, active-high reset.
- enBM  input  CH  per-channel run enable, level sensitive.
- oneshotBM  input  CH  per-channel mode: 1 = one period then stop, 0 = continuous.
- lastBM  input  CH*CW  per-channel last count value; channel i uses bits [i*CW +: CW].
- highBM  input  CH*CW  per-channel last flag-high count; same packing as lastBM.
- BandBM  output  CH  per-channel timing flag, registered.
- wrapBM  output  CH  one-cycle pulse marking the first cycle of a new period after a wrap, registered.
- doneBM  output  CH  one-shot complete, held until enable drops, registered.
- activeBM  output  CH  channel in RUN state, registered.

Behaviour:
- Reset (asynchronous, resetBM=1):
  - All channels go to IDLE; cnt=0.
  - BandBM, wrapBM, doneBM and activeBM are all 0.
  - Latched last=DEF_LAST, latched high=DEF_HIGH.
- Per-channel states: IDLE, RUN, DONE. Channels are fully independent; there is no shared state.
- IDLE, enBM[i]=0: hold; all outputs 0.
- IDLE, enBM[i]=1 at an edge:
  - Go to RUN.
  - Latch lastBM/highBM slices and the oneshot bit.
  - cnt<=0, BandBM<=1, activeBM<=1, wrapBM<=0.
- RUN, enBM[i]=1, cnt != last_l:
  - cnt<=cnt+1.
  - BandBM<=(cnt+1 <= high_l), unsigned compare.
  - wrapBM<=0.
- RUN, enBM[i]=1, cnt == last_l, continuous mode:
  - cnt<=0; relatch config from inputs.
  - BandBM<=1, wrapBM<=1 for one cycle.
- RUN, enBM[i]=1, cnt == last_l, one-shot mode:
  - Go to DONE.
  - BandBM<=0, activeBM<=0, doneBM<=1, wrapBM<=1 for one cycle.
- DONE, enBM[i]=1: hold; doneBM=1, other outputs 0. No restart until enable has been low for at least one edge.
- RUN or DONE, enBM[i]=0 at an edge:
  - Go to IDLE; cnt<=0.
  - BandBM, wrapBM, doneBM and activeBM all <=0.
  - Enable low dominates any simultaneous wrap, so no wrap pulse is produced.
- Latency: outputs are registered. The flag rises at the first edge that samples en=1, and falls at the first edge that samples en=0. This differs from the older combinational flag.
- Config stability:
  - lastBM/highBM changes while RUN are ignored until the next wrap or restart.
  - The latched values are what every compare uses.
- Boundaries:
  - last=0 gives a period of 1; in continuous mode wrapBM and BandBM stay 1 every cycle.
  - high>=last keeps the flag high for the whole period.
  - high=0 gives a flag for exactly one cycle per period.
  - The counter never exceeds last_l, so no CW overflow occurs; last=2^CW-1 is legal (period 2^CW).
- Reset mid-period: immediate return to IDLE with defaults relatched. After release, a still-high enable starts a fresh period at the next edge.

Test Plan:
- Continuous default: CH0, en=1, oneshot=0, last=24, high=10.
  - BandBM[0]: 11 cycles high, 14 low, repeating with period 25.
  - wrapBM[0]: 1-cycle pulse every 25 cycles, coincident with the first high cycle of each new period.
- One-shot: CH1, last=7, high=2, oneshot=1, en held high.
  - BandBM[1] high 3 cycles then low 5.
  - wrapBM[1] and doneBM[1] rise together 8 cycles after start; doneBM stays 1.
  - Dropping en clears doneBM next edge; re-raising en restarts the period.
- Enable drop mid-period: CH2 defaults, en low at count 5.
  - BandBM[2] falls at the next edge; activeBM falls at the same edge.
  - No wrapBM pulse.
  - Re-enable gives BandBM high 11 cycles from count 0.
- Edge configs: CH3 last=0 continuous gives BandBM=wrapBM=1 every cycle. Then high=31, last=31 gives the flag high for all 32 cycles with a wrap every 32.
- Config change mid-run: CH0 running 24/10; at count 3 set last=9, high=4.
  - Current period still 25 cycles with 11 high.
  - Next period 10 cycles with 5 high.
- Reset and independence: all four channels running with different configs; pulse resetBM between edges.
  - All outputs go to 0 asynchronously.
  - After release, each channel restarts independently and one channel's enable does not disturb the others.
